outpkt_checksum_ins: RTL and testbench

Parametrised checksum inserter for the outgoing packet stream of pkt_comm. It sits between the packet builder and the output FIFO. It passes 16-bit words through and inserts a 4-byte inverted running checksum after the packet header and after the end of packet data. With the interval option compiled in, it also inserts a checksum after every CHECKSUM_INTERVAL bytes of data. It also flags protocol errors where a new packet starts in the middle of a packet.

---
 rtl/outpkt_checksum_ins_if.sv | 21 ++
 rtl/outpkt_checksum_ins.sv | 197 +++++++++++++++++++
 tb/tb_outpkt_checksum_ins.sv | 217 +++++++++++++++++++++
 3 files changed

// File: rtl/outpkt_checksum_ins_if.sv
// Word-stream handshake between the packet builder, the checksum inserter and the output FIFO.
interface outpkt_checksum_ins_if;
    logic [15:0] din;
    logic        pkt_new;
    logic        pkt_end;
    logic        wr_en;
    logic        full;
    logic [15:0] dout;
    logic        rd_en;
    logic        empty;

    modport slave (
        input  din, pkt_new, pkt_end, wr_en, rd_en,
        output full, dout, empty
    );

    modport master (
        output din, pkt_new, pkt_end, wr_en, rd_en,
        input  full, dout, empty
    );
endinterface

// File: rtl/outpkt_checksum_ins.sv
// Inserts an inverted 32-bit running checksum after each header and packet end.
// Define OUTPKT_CHECKSUM_INTERVAL_EN to also insert one every CHECKSUM_INTERVAL data bytes.
module outpkt_checksum_ins #(
    parameter int unsigned HEADER_LEN        = 10,
    parameter int unsigned CHECKSUM_INTERVAL = 448
) (
    input  logic                  CLK,
    input  logic                  RST,
    outpkt_checksum_ins_if.slave  bus,
    output logic                  err_pkt_new
);

    localparam int unsigned HDR_WORDS = HEADER_LEN / 2;
`ifdef OUTPKT_CHECKSUM_INTERVAL_EN
    localparam int unsigned INT_WORDS = CHECKSUM_INTERVAL / 2;
    localparam int unsigned CNT_MAX   = (HDR_WORDS > INT_WORDS) ? HDR_WORDS : INT_WORDS;
`else
    localparam int unsigned CNT_MAX   = HDR_WORDS;
`endif
    localparam int unsigned CNT_W = $clog2(CNT_MAX + 1);
    localparam logic [CNT_W-1:0] HDR_LAST = CNT_W'(HDR_WORDS - 1);
`ifdef OUTPKT_CHECKSUM_INTERVAL_EN
    localparam logic [CNT_W-1:0] INT_LAST = CNT_W'(INT_WORDS - 1);
`endif

    typedef enum logic [1:0] {S_PASS, S_FOLD, S_CK_LO, S_CK_HI} state_t;
    typedef enum logic {SEG_HDR, SEG_DATA} seg_t;

    state_t           state_q, state_d;
    seg_t             seg_q, seg_d;
    logic [CNT_W-1:0] cnt_q, cnt_d;
    logic [31:0]      sum_q, sum_d;
    logic             pend_q, pend_d;
    logic [15:0]      pend_word_q, pend_word_d;
    logic             at_start_q, at_start_d;
    logic             err_q, err_d;
    logic [15:0]      in_word_q, in_word_d;
    logic             in_new_q, in_new_d;
    logic             in_end_q, in_end_d;
    logic             full_q, full_d;
    logic [15:0]      out_word_q, out_word_d;
    logic             empty_q, empty_d;

    logic             out_free, drain, accept, boundary;
    seg_t             seg_cur;
    logic [CNT_W-1:0] cnt_cur;
    logic             pend_cur;
    logic [31:0]      sum_cur;

    always_comb begin
        state_d     = state_q;
        seg_d       = seg_q;
        cnt_d       = cnt_q;
        sum_d       = sum_q;
        pend_d      = pend_q;
        pend_word_d = pend_word_q;
        at_start_d  = at_start_q;
        err_d       = err_q;
        in_word_d   = in_word_q;
        in_new_d    = in_new_q;
        in_end_d    = in_end_q;
        full_d      = full_q;
        out_word_d  = out_word_q;
        empty_d     = empty_q;
        boundary    = 1'b0;

        // pkt_new restarts pairing, sum and segment on the word that carries it
        seg_cur  = in_new_q ? SEG_HDR : seg_q;
        cnt_cur  = in_new_q ? '0      : cnt_q;
        pend_cur = in_new_q ? 1'b0    : pend_q;
        sum_cur  = in_new_q ? '0      : sum_q;

        out_free = empty_q | bus.rd_en;
        drain    = (state_q == S_PASS) & full_q & out_free;
        accept   = bus.wr_en & (~full_q | drain);

        if (accept) begin
            in_word_d = bus.din;
            in_new_d  = bus.pkt_new;
            in_end_d  = bus.pkt_end;
            full_d    = 1'b1;
        end else if (drain) begin
            full_d = 1'b0;
        end

        if (bus.rd_en & ~empty_q)
            empty_d = 1'b1;

        case (state_q)
            S_PASS: begin
                if (drain) begin
                    out_word_d = in_word_q;
                    empty_d    = 1'b0;
                    at_start_d = 1'b0;
                    if (in_new_q && !at_start_q)
                        err_d = 1'b1;

                    if (pend_cur) begin
                        sum_d  = sum_cur + {in_word_q, pend_word_q};
                        pend_d = 1'b0;
                    end else begin
                        sum_d       = sum_cur;
                        pend_word_d = in_word_q;
                        pend_d      = 1'b1;
                    end

                    if (seg_cur == SEG_HDR) begin
                        if (cnt_cur == HDR_LAST) begin
                            boundary = 1'b1;
                            seg_d    = SEG_DATA;
                        end else begin
                            seg_d = SEG_HDR;
                        end
                    end else if (in_end_q) begin
                        boundary   = 1'b1;
                        seg_d      = SEG_HDR;
                        at_start_d = 1'b1;
                    end
`ifdef OUTPKT_CHECKSUM_INTERVAL_EN
                    else if (cnt_cur == INT_LAST) begin
                        boundary = 1'b1;
                    end
                    cnt_d = boundary ? '0 : cnt_cur + 1'b1;
`else
                    cnt_d = (boundary || seg_cur != SEG_HDR) ? '0 : cnt_cur + 1'b1;
`endif
                    // a word left unpaired must be folded in before emission
                    if (boundary)
                        state_d = pend_cur ? S_CK_LO : S_FOLD;
                end
            end
            S_FOLD: begin
                sum_d   = sum_q + {16'h0000, pend_word_q};
                pend_d  = 1'b0;
                state_d = S_CK_LO;
            end
            S_CK_LO: begin
                if (out_free) begin
                    out_word_d = ~sum_q[15:0];
                    empty_d    = 1'b0;
                    state_d    = S_CK_HI;
                end
            end
            S_CK_HI: begin
                if (out_free) begin
                    out_word_d = ~sum_q[31:16];
                    empty_d    = 1'b0;
                    sum_d      = '0;
                    pend_d     = 1'b0;
                    cnt_d      = '0;
                    state_d    = S_PASS;
                end
            end
            default: state_d = S_PASS;
        endcase
    end

    always_ff @(posedge CLK) begin
        if (RST) begin
            state_q     <= S_PASS;
            seg_q       <= SEG_HDR;
            cnt_q       <= '0;
            sum_q       <= '0;
            pend_q      <= 1'b0;
            pend_word_q <= '0;
            at_start_q  <= 1'b1;
            err_q       <= 1'b0;
            in_word_q   <= '0;
            in_new_q    <= 1'b0;
            in_end_q    <= 1'b0;
            full_q      <= 1'b0;
            out_word_q  <= '0;
            empty_q     <= 1'b1;
        end else begin
            state_q     <= state_d;
            seg_q       <= seg_d;
            cnt_q       <= cnt_d;
            sum_q       <= sum_d;
            pend_q      <= pend_d;
            pend_word_q <= pend_word_d;
            at_start_q  <= at_start_d;
            err_q       <= err_d;
            in_word_q   <= in_word_d;
            in_new_q    <= in_new_d;
            in_end_q    <= in_end_d;
            full_q      <= full_d;
            out_word_q  <= out_word_d;
            empty_q     <= empty_d;
        end
    end

    assign bus.full    = full_q;
    assign bus.dout    = out_word_q;
    assign bus.empty   = empty_q;
    assign err_pkt_new = err_q;

endmodule

// File: tb/tb_outpkt_checksum_ins.sv
// Directed checks of outpkt_checksum_ins against hand-computed checksum words.
module tb_outpkt_checksum_ins;
    logic CLK = 1'b0;
    logic RST = 1'b1;
    logic err;
    int   n_assert = 0;
    int   n_fail   = 0;
    logic [15:0] got[$];

    outpkt_checksum_ins_if bus();

    outpkt_checksum_ins #(
        .HEADER_LEN        (10),
        .CHECKSUM_INTERVAL (8)
    ) dut (
        .CLK         (CLK),
        .RST         (RST),
        .bus         (bus),
        .err_pkt_new (err)
    );

    always #5 CLK = ~CLK;

    // a word visible with rd_en high at the falling edge is consumed at the next rising edge
    always @(negedge CLK)
        if (!RST && bus.rd_en && !bus.empty)
            got.push_back(bus.dout);

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_assert++;
        assert (obs === exp) else begin
            n_fail++;
            $error("FAIL %s: observed 0x%0h expected 0x%0h", tag, obs, exp);
        end
    endtask

    task automatic tick();
        @(posedge CLK);
        #1;
    endtask

    task automatic send(input logic [15:0] w, input logic n, input logic e);
        int t = 0;
        while (bus.full && t < 100) begin
            tick();
            t++;
        end
        chk("send_full_clear", {31'b0, bus.full}, 32'd0);
        bus.din     = w;
        bus.pkt_new = n;
        bus.pkt_end = e;
        bus.wr_en   = 1'b1;
        tick();
        bus.wr_en   = 1'b0;
        bus.pkt_new = 1'b0;
        bus.pkt_end = 1'b0;
    endtask

    task automatic expect_word(input string tag, input logic [15:0] exp);
        int t = 0;
        logic [15:0] w;
        while (got.size() == 0 && t < 100) begin
            tick();
            t++;
        end
        chk({tag, "_avail"}, {31'b0, (got.size() != 0)}, 32'd1);
        if (got.size() != 0) begin
            w = got.pop_front();
            chk(tag, {16'b0, w}, {16'b0, exp});
        end
    endtask

    task automatic send_header();
        send(16'h0001, 1'b1, 1'b0);
        for (int i = 2; i <= 5; i++)
            send(16'(i), 1'b0, 1'b0);
    endtask

    task automatic expect_header(input string tag);
        for (int i = 1; i <= 5; i++)
            expect_word(tag, 16'(i));
        expect_word({tag, "_ck_lo"}, 16'hFFF6);
        expect_word({tag, "_ck_hi"}, 16'hFFF9);
    endtask

    initial begin
        bus.din     = '0;
        bus.pkt_new = 1'b0;
        bus.pkt_end = 1'b0;
        bus.wr_en   = 1'b0;
        bus.rd_en   = 1'b1;
        RST         = 1'b1;
        repeat (2) tick();
        chk("rst_full",  {31'b0, bus.full},  32'd0);
        chk("rst_empty", {31'b0, bus.empty}, 32'd1);
        chk("rst_err",   {31'b0, err},       32'd0);
        RST = 1'b0;
        tick();

        // header checksum, sum 0x00060009
        send_header();
        expect_header("hdr1");
        chk("err_first_pkt", {31'b0, err}, 32'd0);

        // data and end, sum 0xABCD1234
        send(16'h1234, 1'b0, 1'b0);
        send(16'hABCD, 1'b0, 1'b1);
        expect_word("data_w0", 16'h1234);
        expect_word("data_w1", 16'hABCD);
        expect_word("end_ck_lo", 16'hEDCB);
        expect_word("end_ck_hi", 16'h5432);

        send_header();
        expect_header("hdr2");
        chk("err_after_end", {31'b0, err}, 32'd0);

        // six data words of 0x0001, interval of 4 words when enabled
        for (int i = 1; i <= 6; i++)
            send(16'h0001, 1'b0, (i == 6));
`ifdef OUTPKT_CHECKSUM_INTERVAL_EN
        for (int i = 0; i < 4; i++) expect_word("intv_a", 16'h0001);
        expect_word("intv_ck_lo", 16'hFFFD);
        expect_word("intv_ck_hi", 16'hFFFD);
        for (int i = 0; i < 2; i++) expect_word("intv_b", 16'h0001);
        expect_word("intv_end_lo", 16'hFFFE);
        expect_word("intv_end_hi", 16'hFFFE);
`else
        for (int i = 0; i < 6; i++) expect_word("six_data", 16'h0001);
        expect_word("six_end_lo", 16'hFFFC);
        expect_word("six_end_hi", 16'hFFFC);
`endif

        // wrap-around: sum 0xFFFFFFFE
        send_header();
        expect_header("hdr3");
        for (int i = 1; i <= 4; i++)
            send(16'hFFFF, 1'b0, (i == 4));
        for (int i = 0; i < 4; i++) expect_word("wrap_data", 16'hFFFF);
        expect_word("wrap_ck_lo", 16'h0001);
        expect_word("wrap_ck_hi", 16'h0000);

        // pkt_new on the third data word
        send_header();
        expect_header("hdr4");
        send(16'h0010, 1'b0, 1'b0);
        send(16'h0020, 1'b0, 1'b0);
        tick();
        chk("err_before", {31'b0, err}, 32'd0);
        send(16'h0100, 1'b1, 1'b0);
        tick();
        chk("err_set", {31'b0, err}, 32'd1);
        send(16'h0200, 1'b0, 1'b0);
        send(16'h0300, 1'b0, 1'b0);
        send(16'h0400, 1'b0, 1'b0);
        send(16'h0500, 1'b0, 1'b0);
        expect_word("perr_d0", 16'h0010);
        expect_word("perr_d1", 16'h0020);
        expect_word("perr_h1", 16'h0100);
        expect_word("perr_h2", 16'h0200);
        expect_word("perr_h3", 16'h0300);
        expect_word("perr_h4", 16'h0400);
        expect_word("perr_h5", 16'h0500);
        expect_word("perr_ck_lo", 16'hF6FF);
        expect_word("perr_ck_hi", 16'hF9FF);
        send(16'h0003, 1'b0, 1'b1);
        expect_word("fold_data", 16'h0003);
        expect_word("fold_ck_lo", 16'hFFFC);
        expect_word("fold_ck_hi", 16'hFFFF);
        chk("err_sticky", {31'b0, err}, 32'd1);

        // backpressure with the low checksum word held on dout
        send_header();
        expect_header("hdr5");
        send(16'h1111, 1'b0, 1'b0);
        send(16'h2222, 1'b0, 1'b1);
        send(16'h0007, 1'b1, 1'b0);
        bus.rd_en = 1'b0;
        for (int i = 0; i < 5; i++) begin
            tick();
            chk("bp_dout",  {16'b0, bus.dout},  {16'b0, 16'hEEEE});
            chk("bp_full",  {31'b0, bus.full},  32'd1);
            chk("bp_empty", {31'b0, bus.empty}, 32'd0);
        end
        bus.rd_en = 1'b1;
        expect_word("bp_d0", 16'h1111);
        expect_word("bp_d1", 16'h2222);
        expect_word("bp_ck_lo", 16'hEEEE);
        expect_word("bp_ck_hi", 16'hDDDD);
        expect_word("bp_h1", 16'h0007);
        chk("bp_err_kept", {31'b0, err}, 32'd1);

        // reset mid-header, with a write presented during the reset cycle
        send(16'h0008, 1'b0, 1'b0);
        expect_word("pre_rst_h2", 16'h0008);
        bus.din   = 16'hBEEF;
        bus.wr_en = 1'b1;
        RST       = 1'b1;
        tick();
        RST       = 1'b0;
        bus.wr_en = 1'b0;
        chk("rst2_full",  {31'b0, bus.full},  32'd0);
        chk("rst2_empty", {31'b0, bus.empty}, 32'd1);
        chk("rst2_err",   {31'b0, err},       32'd0);
        tick();
        chk("rst2_empty_hold", {31'b0, bus.empty}, 32'd1);
        chk("rst2_no_words", 32'(got.size()), 32'd0);

        send_header();
        expect_header("hdr_post_rst");
        chk("err_post_rst", {31'b0, err}, 32'd0);
        repeat (5) tick();
        chk("no_extra_words", 32'(got.size()), 32'd0);

        $display("End of test - %0d assertions evaluated, %0d failures", n_assert, n_fail);
        $finish;
    end
endmodule
